// File: rtl/player_pkg.sv
// Shared types and key codes for the player motion controller.
package player_pkg;

    typedef logic [11:0] coord_t;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

    localparam logic [6:0] KEY_D     = 7'h44;
    localparam logic [6:0] KEY_d     = 7'h64;
    localparam logic [6:0] KEY_A     = 7'h41;
    localparam logic [6:0] KEY_a     = 7'h61;
    localparam logic [6:0] KEY_W     = 7'h57;
    localparam logic [6:0] KEY_w     = 7'h77;
    localparam logic [6:0] KEY_SPACE = 7'h20;

endpackage

// File: rtl/tick_divider.sv
// Tick-paced modulo-DIV counter; step pulses on the tick that wraps it.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clear,
    input  logic run,
    output logic step
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    always_comb begin
        step     = run && tick && (cnt_reg == LAST);
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (run) begin
            cnt_next = (cnt_reg == LAST) ? 8'd0 : cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Frame-tick-paced player walking with a one-shot jump state machine.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int X_INIT      = 40,
    parameter int Y_GROUND    = 100,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 984,
    parameter int STEP_DIV    = 10,
    parameter int JUMP_HEIGHT = 32,
    parameter int JUMP_DIV    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [6:0] keyCode,
    output coord_t     xpos,
    output coord_t     ypos,
    output logic       dir,
    output logic       airborne
);

    localparam coord_t     X_INIT_C   = coord_t'(X_INIT);
    localparam coord_t     Y_GROUND_C = coord_t'(Y_GROUND);
    localparam coord_t     X_MIN_C    = coord_t'(X_MIN);
    localparam coord_t     X_MAX_C    = coord_t'(X_MAX);
    localparam logic [7:0] HEIGHT_C   = 8'(JUMP_HEIGHT);

    jump_state_t state_reg, state_next;
    coord_t      xpos_reg, xpos_next;
    coord_t      ypos_reg, ypos_next;
    logic        dir_reg, dir_next;
    logic        airborne_reg, airborne_next;
    logic        armed_reg, armed_next;
    logic [7:0]  rise_reg, rise_next;

    logic key_right, key_left, key_jump, key_horiz;
    logic h_run, h_step, v_run, v_step;

    always_comb begin
        key_right = (keyCode == KEY_D) || (keyCode == KEY_d);
        key_left  = (keyCode == KEY_A) || (keyCode == KEY_a);
        key_jump  = (keyCode == KEY_W) || (keyCode == KEY_w) || (keyCode == KEY_SPACE);
        key_horiz = key_right || key_left;
        // Counting only while the held key agrees with the facing direction.
        h_run     = key_horiz && (key_left == dir_reg);
        v_run     = (state_reg != GROUND);
    end

    tick_divider #(.DIV(STEP_DIV)) u_h_div (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clear (!h_run),
        .run   (h_run),
        .step  (h_step)
    );

    tick_divider #(.DIV(JUMP_DIV)) u_v_div (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clear (!v_run),
        .run   (v_run),
        .step  (v_step)
    );

    always_comb begin
        state_next = state_reg;
        xpos_next  = xpos_reg;
        ypos_next  = ypos_reg;
        dir_next   = dir_reg;
        rise_next  = rise_reg;
        armed_next = armed_reg;

        if (key_horiz && (key_left != dir_reg)) begin
            dir_next = key_left;
        end
        if (h_step) begin
            if (key_right && (xpos_reg < X_MAX_C)) begin
                xpos_next = xpos_reg + 12'd1;
            end else if (key_left && (xpos_reg > X_MIN_C)) begin
                xpos_next = xpos_reg - 12'd1;
            end
        end

        if (!key_jump) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            GROUND: begin
                if (key_jump && armed_reg) begin
                    state_next = RISE;
                    rise_next  = '0;
                    armed_next = 1'b0;
                end
            end
            RISE: begin
                if (v_step) begin
                    ypos_next = ypos_reg - 12'd1;
                    rise_next = rise_reg + 8'd1;
                    if (rise_next == HEIGHT_C) begin
                        state_next = FALL;
                    end
                end
            end
            FALL: begin
                if (v_step) begin
                    ypos_next = ypos_reg + 12'd1;
                    if (ypos_next == Y_GROUND_C) begin
                        state_next = GROUND;
                    end
                end
            end
            default: state_next = GROUND;
        endcase

        airborne_next = (state_next != GROUND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= GROUND;
            xpos_reg     <= X_INIT_C;
            ypos_reg     <= Y_GROUND_C;
            dir_reg      <= 1'b0;
            airborne_reg <= 1'b0;
            armed_reg    <= 1'b1;
            rise_reg     <= '0;
        end else if (tick) begin
            state_reg    <= state_next;
            xpos_reg     <= xpos_next;
            ypos_reg     <= ypos_next;
            dir_reg      <= dir_next;
            airborne_reg <= airborne_next;
            armed_reg    <= armed_next;
            rise_reg     <= rise_next;
        end
    end

    assign xpos     = xpos_reg;
    assign ypos     = ypos_reg;
    assign dir      = dir_reg;
    assign airborne = airborne_reg;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl plus a narrow-bounds instance.
module tb_player_motion_ctrl;
    import player_pkg::*;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        d;
        logic        a;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [6:0] key_code = 7'h00;
    coord_t     xpos, ypos;
    logic       dir, airborne;

    logic       tick_b = 1'b0;
    logic [6:0] key_b = 7'h00;
    coord_t     xpos_b, ypos_b;
    logic       dir_b, air_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    exp_t sb_q[$];

    // Reference model state (default parameters)
    int m_x, m_y, m_dir, m_hc, m_vc, m_rise, m_armed, m_st;

    always #5 clk = ~clk;

    player_motion_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .keyCode(key_code),
        .xpos(xpos), .ypos(ypos), .dir(dir), .airborne(airborne)
    );

    player_motion_ctrl #(.X_MIN(38), .X_MAX(45)) dut_b (
        .clk(clk), .rst(rst), .tick(tick_b), .keyCode(key_b),
        .xpos(xpos_b), .ypos(ypos_b), .dir(dir_b), .airborne(air_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_x = 40; m_y = 100; m_dir = 0; m_hc = 0; m_vc = 0;
        m_rise = 0; m_armed = 1; m_st = 0;
    endtask

    task automatic model_tick(input logic [6:0] k);
        bit r, l, j;
        r = (k == 7'h44) || (k == 7'h64);
        l = (k == 7'h41) || (k == 7'h61);
        j = (k == 7'h57) || (k == 7'h77) || (k == 7'h20);
        if (r || l) begin
            if (int'(l) != m_dir) begin
                m_dir = int'(l);
                m_hc  = 0;
            end else if (m_hc == 9) begin
                m_hc = 0;
                if (r && m_x < 984) m_x++;
                if (l && m_x > 0) m_x--;
            end else begin
                m_hc++;
            end
        end else begin
            m_hc = 0;
        end
        case (m_st)
            0: if (j && m_armed == 1) begin
                   m_st = 1; m_vc = 0; m_rise = 0; m_armed = 0;
               end
            1: begin
                   m_vc++;
                   if (m_vc == 2) begin
                       m_vc = 0; m_y--; m_rise++;
                       if (m_rise == 32) m_st = 2;
                   end
               end
            default: begin
                   m_vc++;
                   if (m_vc == 2) begin
                       m_vc = 0; m_y++;
                       if (m_y == 100) m_st = 0;
                   end
               end
        endcase
        if (!j) m_armed = 1;
    endtask

    task automatic push_expected();
        exp_t e;
        e.x = 12'(m_x);
        e.y = 12'(m_y);
        e.d = 1'(m_dir);
        e.a = (m_st != 0);
        sb_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        n_txn++;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        $display("txn %0d %s: x=%0d y=%0d dir=%0d air=%0d", n_txn, tag, xpos, ypos, dir, airborne);
        check({tag, "_x"}, 32'(xpos), 32'(e.x));
        check({tag, "_y"}, 32'(ypos), 32'(e.y));
        check({tag, "_dir"}, 32'(dir), 32'(e.d));
        check({tag, "_air"}, 32'(airborne), 32'(e.a));
    endtask

    task automatic expect_now(input string tag);
        push_expected();
        pop_compare(tag);
    endtask

    task automatic do_tick(input logic [6:0] k);
        @(negedge clk);
        key_code = k;
        tick     = 1'b1;
        model_tick(k);
        push_expected();
        @(negedge clk);
        tick = 1'b0;
        pop_compare("tick");
    endtask

    task automatic idle_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_expected();
            pop_compare("idle");
        end
    endtask

    task automatic tick_b_n(input logic [6:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            key_b  = k;
            tick_b = 1'b1;
            @(negedge clk);
            tick_b = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        expect_now("reset");
        rst = 1'b1;
        @(negedge clk);
        expect_now("post_reset");
        check("b_reset_x", 32'(xpos_b), 32'd40);

        // Walk right: steps on held ticks 10 and 20
        repeat (25) do_tick(7'h64);
        check("walk25_x", 32'(xpos), 32'd42);
        do_tick(7'h00);
        repeat (9) do_tick(7'h64);
        check("walk_resume_x", 32'(xpos), 32'd42);

        // Asynchronous reset in the middle of a walk
        @(negedge clk);
        key_code = 7'h64;
        rst      = 1'b0;
        #1;
        model_reset();
        expect_now("async_rst");
        check("async_rst_x", 32'(xpos), 32'd40);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_now("rst_release");

        // Direction changes restart the divider
        repeat (9) do_tick(7'h61);
        check("left9_dir", 32'(dir), 32'd1);
        check("left9_x", 32'(xpos), 32'd40);
        repeat (9) do_tick(7'h44);
        check("right9_dir", 32'(dir), 32'd0);
        check("right9_x", 32'(xpos), 32'd40);

        // Jump with key held throughout
        do_tick(7'h20);
        check("jump_air", 32'(airborne), 32'd1);
        repeat (64) do_tick(7'h20);
        check("jump_top_y", 32'(ypos), 32'd68);
        repeat (64) do_tick(7'h20);
        check("land_y", 32'(ypos), 32'd100);
        check("land_air", 32'(airborne), 32'd0);
        repeat (20) do_tick(7'h20);
        check("no_rejump_air", 32'(airborne), 32'd0);

        // Jump while walking; outputs frozen without ticks
        do_tick(7'h00);
        do_tick(7'h20);
        repeat (5) do_tick(7'h44);
        key_code = 7'h44;
        idle_clks(50);
        repeat (40) do_tick(7'h44);
        check("jw_x", 32'(xpos), 32'd44);
        check("jw_y", 32'(ypos), 32'd78);
        repeat (20) do_tick(7'h44);
        check("jw_fall_x", 32'(xpos), 32'd46);
        repeat (10) do_tick(7'h20);
        check("fall_rejump_y", 32'(ypos), 32'd73);
        check("fall_rejump_air", 32'(airborne), 32'd1);
        repeat (60) do_tick(7'h00);
        check("jw_land_y", 32'(ypos), 32'd100);
        check("jw_land_air", 32'(airborne), 32'd0);

        // Bounds on the narrow instance
        tick_b_n(7'h44, 100);
        check("b_max_x", 32'(xpos_b), 32'd45);
        check("b_max_dir", 32'(dir_b), 32'd0);
        tick_b_n(7'h41, 100);
        check("b_min_x", 32'(xpos_b), 32'd38);
        check("b_min_dir", 32'(dir_b), 32'd1);
        check("b_y", 32'(ypos_b), 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
